spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 29 ++
 rtl/spi_slave_if.sv | 10 +
 rtl/spi_sync.sv | 29 ++
 rtl/spi_slave.sv | 143 ++++++++++++++
 tb/tb_spi_slave.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_pkg.sv
// Shared constants, types and bit-order helpers for the SPI slave.
// Bit order follows SPI_SLAVE_LSB_FIRST_EN (defined: LSB first, undefined: MSB first).
package spi_slave_pkg;

    localparam int SPI_BYTE_W = 8;
    localparam int SPI_CNT_W  = 3;

    typedef logic [SPI_BYTE_W-1:0] spi_byte_t;
    typedef logic [SPI_CNT_W-1:0]  spi_cnt_t;

    // Index of the transmit bit presented while the bit counter holds cnt.
    function automatic spi_cnt_t tx_bit_idx(input spi_cnt_t cnt);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return cnt;
`else
        return spi_cnt_t'(SPI_BYTE_W - 1) - cnt;
`endif
    endfunction

    // Full byte formed by the seven bits already shifted in plus the current MOSI bit.
    function automatic spi_byte_t rx_assemble(input logic [SPI_BYTE_W-2:0] cur, input logic bit_in);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return {bit_in, cur};
`else
        return {cur, bit_in};
`endif
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin bundle (mode 0) between a bus master and the slave.
interface spi_slave_if;
    logic nCS;
    logic SCK;
    logic MOSI;
    logic MISO;

    modport master (output nCS, output SCK, output MOSI, input MISO);
    modport slave  (input nCS, input SCK, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer into the clk domain; reset loads every stage with rst_val.
module spi_sync #(
    parameter int STAGES = 2    // legal range 2..4
) (
    input  logic clk,
    input  logic reset,
    input  logic rst_val,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{rst_val}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: SCK-domain shifter plus clk-domain byte/transfer event handoff.
// Optional macro SPI_SLAVE_LSB_FIRST_EN selects LSB-first receive and transmit.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    spi_slave_if.slave      spi,
    output spi_byte_t       mosi_data,
    input  spi_byte_t       miso_data,
    output logic            next_byte_ready,
    output logic            new_transfer
);

    logic ncs;
    logic sck;

    assign ncs = spi.nCS;
    assign sck = spi.SCK;

    // ---------------- SCK domain ----------------
    spi_cnt_t                bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-2:0]   rx_shift_q, rx_shift_d;
    spi_byte_t               rx_byte;
    spi_byte_t               hold_q, hold_d;
    logic                    tgl_q, tgl_d;
    spi_byte_t               tx_q, tx_d;
    spi_cnt_t                cnt_fall_q, cnt_fall_d;
    logic                    miso_bit_q, miso_bit_d;

    always_comb begin
        bit_cnt_d  = bit_cnt_q + spi_cnt_t'(1);
        rx_byte    = rx_assemble(rx_shift_q, spi.MOSI);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        rx_shift_d = rx_byte[SPI_BYTE_W-1:1];
`else
        rx_shift_d = rx_byte[SPI_BYTE_W-2:0];
`endif
        hold_d     = hold_q;
        tgl_d      = tgl_q;
        tx_d       = tx_q;
        if (bit_cnt_q == spi_cnt_t'(SPI_BYTE_W - 1)) begin
            hold_d = rx_byte;
            tgl_d  = ~tgl_q;
        end
        if (bit_cnt_q == spi_cnt_t'(0)) begin
            tx_d = miso_data;
        end
        cnt_fall_d = bit_cnt_q;
        miso_bit_d = tx_q[tx_bit_idx(bit_cnt_q)];
    end

    always_ff @(posedge sck or posedge ncs) begin
        if (ncs) begin
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Hold register and toggle are never cleared, so a deselect cannot fake a byte event.
    always_ff @(posedge sck) begin
        if (!ncs) begin
            hold_q <= hold_d;
            tgl_q  <= tgl_d;
            tx_q   <= tx_d;
        end
    end

    // Falling-edge copy of the counter keeps MISO changes off the sampling edge.
    always_ff @(negedge sck or posedge ncs) begin
        if (ncs) begin
            cnt_fall_q <= '0;
            miso_bit_q <= 1'b0;
        end else begin
            cnt_fall_q <= cnt_fall_d;
            miso_bit_q <= miso_bit_d;
        end
    end

    assign spi.MISO = ncs ? 1'b0
                    : (cnt_fall_q == spi_cnt_t'(0)) ? miso_data[tx_bit_idx(spi_cnt_t'(0))]
                    : miso_bit_q;

    // ---------------- clk domain ----------------
    logic       ncs_s;
    logic       tgl_s;
    logic       ncs_prev_q, ncs_prev_d;
    logic       tgl_prev_q, tgl_prev_d;
    spi_byte_t  mosi_data_q, mosi_data_d;
    logic       nbr_q, nbr_d;
    logic       nt_q, nt_d;

    spi_sync #(.STAGES(SYNC_STAGES)) u_ncs_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_val (1'b1),
        .d       (ncs),
        .q       (ncs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES)) u_tgl_sync (
        .clk     (clk),
        .reset   (reset),
        .rst_val (tgl_q),
        .d       (tgl_q),
        .q       (tgl_s)
    );

    always_comb begin
        ncs_prev_d  = ncs_s;
        tgl_prev_d  = tgl_s;
        nt_d        = ncs_prev_q & ~ncs_s;
        nbr_d       = tgl_s ^ tgl_prev_q;
        mosi_data_d = nbr_d ? hold_q : mosi_data_q;
    end

    // Edge flops reset to the live toggle so bytes finishing during reset are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            ncs_prev_q  <= 1'b1;
            tgl_prev_q  <= tgl_q;
            mosi_data_q <= '0;
            nbr_q       <= 1'b0;
            nt_q        <= 1'b0;
        end else begin
            ncs_prev_q  <= ncs_prev_d;
            tgl_prev_q  <= tgl_prev_d;
            mosi_data_q <= mosi_data_d;
            nbr_q       <= nbr_d;
            nt_q        <= nt_d;
        end
    end

    assign mosi_data       = mosi_data_q;
    assign next_byte_ready = nbr_q;
    assign new_transfer    = nt_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master task drives the bus, a monitor counts host-side pulses.
module tb_spi_slave;
    import spi_slave_pkg::*;

    localparam time HALF = 12;

    logic       clk;
    logic       reset;
    spi_byte_t  mosi_data;
    spi_byte_t  miso_data;
    logic       next_byte_ready;
    logic       new_transfer;

    spi_slave_if bus();

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .spi             (bus),
        .mosi_data       (mosi_data),
        .miso_data       (miso_data),
        .next_byte_ready (next_byte_ready),
        .new_transfer    (new_transfer)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int nt_cnt   = 0;
    int nbr_cnt  = 0;
    int cyc      = 0;
    int nt_cyc   = 0;
    int nbr_cyc  = 0;
    spi_byte_t rx_log[$];

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (new_transfer) begin
                nt_cnt++;
                nt_cyc = cyc;
            end
            if (next_byte_ready) begin
                nbr_cnt++;
                nbr_cyc = cyc;
                rx_log.push_back(mosi_data);
                $display("byte event: mosi_data=%02h at cycle %0d", mosi_data, cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cs_low();
        bus.nCS = 1'b0;
        #(HALF);
    endtask

    task automatic cs_high();
        #(HALF);
        bus.nCS = 1'b1;
    endtask

    task automatic send_bits(input spi_byte_t tx, input int nbits, output spi_byte_t rx);
        rx = '0;
        for (int k = 0; k < nbits; k++) begin
            int idx;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            idx = k;
`else
            idx = 7 - k;
`endif
            bus.MOSI = tx[idx];
            #(HALF);
            rx[idx]  = bus.MISO;
            bus.SCK  = 1'b1;
            #(HALF);
            bus.SCK  = 1'b0;
        end
        $display("xfer: sent %02h (%0d bits), master read %02h", tx, nbits, rx);
    endtask

    initial begin
        int base_nt;
        int base_nbr;
        spi_byte_t rx_a;
        spi_byte_t rx_b;

        reset    = 1'b0;
        bus.nCS  = 1'b1;
        bus.SCK  = 1'b0;
        bus.MOSI = 1'b0;
        miso_data = 8'h00;
        #5  reset = 1'b1;
        #22 reset = 1'b0;
        #200;
        chk("idle_mosi_data", mosi_data, 8'h00);
        chk("idle_new_transfer", nt_cnt, 0);
        chk("idle_next_byte_ready", nbr_cnt, 0);
        chk("idle_miso", bus.MISO, 1'b0);

        // single byte 24, slave sends 00
        base_nt = nt_cnt; base_nbr = nbr_cnt; rx_log.delete();
        cs_low();
        send_bits(8'h24, 8, rx_a);
        cs_high();
        #100;
        chk("t1_new_transfer", nt_cnt - base_nt, 1);
        chk("t1_next_byte_ready", nbr_cnt - base_nbr, 1);
        chk("t1_logged_byte", rx_log[0], 8'h24);
        chk("t1_mosi_data", mosi_data, 8'h24);
        chk("t1_master_rx", rx_a, 8'h00);
        chk("t1_order", (nt_cyc < nbr_cyc), 1'b1);

        miso_data = 8'h81;
        #20;
        chk("deselected_miso_zero", bus.MISO, 1'b0);

        // host reply 81 appears in the next transfer
        cs_low();
        chk("t2_first_miso_bit", bus.MISO, 1'b1);
        send_bits(8'h3C, 8, rx_a);
        cs_high();
        #100;
        chk("t2_master_rx", rx_a, 8'h81);
        chk("t2_mosi_data", mosi_data, 8'h3C);

        // back-to-back bytes in one transfer
        base_nt = nt_cnt; base_nbr = nbr_cnt; rx_log.delete();
        cs_low();
        send_bits(8'h09, 8, rx_a);
        send_bits(8'h63, 8, rx_b);
        cs_high();
        #100;
        chk("t3_new_transfer", nt_cnt - base_nt, 1);
        chk("t3_next_byte_ready", nbr_cnt - base_nbr, 2);
        chk("t3_byte0", rx_log[0], 8'h09);
        chk("t3_byte1", rx_log[1], 8'h63);
        chk("t3_master_rx_byte1", rx_b, 8'h81);

        // partial byte discarded, then full byte A5
        base_nt = nt_cnt; base_nbr = nbr_cnt;
        cs_low();
        send_bits(8'hFF, 5, rx_a);
        cs_high();
        #100;
        chk("t4_partial_no_pulse", nbr_cnt - base_nbr, 0);
        chk("t4_partial_new_transfer", nt_cnt - base_nt, 1);
        chk("t4_mosi_data_held", mosi_data, 8'h63);
        cs_low();
        send_bits(8'hA5, 8, rx_a);
        cs_high();
        #100;
        chk("t4_new_transfer_again", nt_cnt - base_nt, 2);
        chk("t4_next_byte_ready", nbr_cnt - base_nbr, 1);
        chk("t4_mosi_data", mosi_data, 8'hA5);
        chk("t4_master_rx", rx_a, 8'h81);

        // transfer entirely inside reset is dropped
        base_nt = nt_cnt; base_nbr = nbr_cnt;
        reset = 1'b1;
        cs_low();
        send_bits(8'h5A, 8, rx_a);
        cs_high();
        #60;
        reset = 1'b0;
        #100;
        chk("t5_no_new_transfer", nt_cnt - base_nt, 0);
        chk("t5_no_next_byte_ready", nbr_cnt - base_nbr, 0);
        chk("t5_mosi_data_reset", mosi_data, 8'h00);

        // byte 24 with reply 01 in the configured bit order
        base_nbr = nbr_cnt;
        miso_data = 8'h01;
        #20;
        cs_low();
        send_bits(8'h24, 8, rx_a);
        cs_high();
        #100;
        chk("t6_next_byte_ready", nbr_cnt - base_nbr, 1);
        chk("t6_mosi_data", mosi_data, 8'h24);
        chk("t6_master_rx", rx_a, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
